// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, hazard controller state and scoreboard entry.
package cpu_types_pkg;

    // MIPS primary opcodes used by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hzd_state_t;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] wsel;
        logic       load;
    } sb_entry_t;

    // True when an in-flight writer produces a register the consumer reads; $0 never hazards
    function automatic logic raw_match(input sb_entry_t e,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       use_rs,
                                       input logic       use_rt);
        return e.valid && e.wen && (e.wsel != 5'd0) &&
               ((use_rs && (rs == e.wsel)) || (use_rt && (rt == e.wsel)));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writers (EX..WB) and RAW hazard detect for ID.
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREG   = 4,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:1] adv,
    input  logic [NREG-1:1] flush,
    input  sb_entry_t       id_entry,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    output logic            hit_c
);

    sb_entry_t sb    [1:NREG-1];
    sb_entry_t sb_in [1:NREG-1];

    // Source of each entry when its pipe register advances
    always_comb begin
        sb_in[1] = id_entry;
        for (int unsigned k = 2; k < NREG; k++) begin
            sb_in[k] = sb[k-1];
        end
    end

    // Shift alongside the pipe registers; a flushed register becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 1; k < NREG; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < NREG; k++) begin
                if (flush[k]) begin
                    sb[k] <= '0;
                end else if (adv[k]) begin
                    sb[k] <= sb_in[k];
                end
            end
        end
    end

    // With forwarding only a load in EX stalls; without it every writer before WB does
    always_comb begin
        hit_c = 1'b0;
        for (int unsigned k = 1; k < NREG; k++) begin
            if (raw_match(sb[k], id_rs, id_rt, id_use_rs, id_use_rt)) begin
                if (FWD_EN) begin
                    if ((k == 1) && sb[k].load) begin
                        hit_c = 1'b1;
                    end
                end else if (k + 1 < NREG) begin
                    hit_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: stall priority mux, dmem wait / halt drain FSM, stall counter.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned NSTAGES  = 5,
    parameter int unsigned BR_STAGE = 2,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               mem_req,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_wen,
    input  logic [4:0]         id_wsel,
    input  logic               id_load,
    input  logic               id_halt,
    input  logic               redirect,
    output logic               pc_wen,
    output logic [NSTAGES-2:0] pr_wen,
    output logic [NSTAGES-2:0] pr_flush,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int unsigned     NREG    = NSTAGES - 1;
    localparam int unsigned     DCNT_W  = $clog2(NREG);
    localparam logic [NREG-1:0] BR_MASK = NREG'((1 << BR_STAGE) - 1);

    hzd_state_t        state;
    hzd_state_t        eff_state;
    logic              ret_drain;
    logic [DCNT_W-1:0] dcnt;

    logic              dwait_c;
    logic              hit_c;
    logic              raw_stall_c;
    logic              halt_go_c;
    logic              pc_wen_c;
    logic [NREG-1:0]   pr_wen_c;
    logic [NREG-1:0]   pr_flush_c;
    sb_entry_t         id_entry;

    assign id_entry = '{valid: id_valid, wen: id_wen, wsel: id_wsel, load: id_load};

    hazard_scoreboard #(
        .NREG   (NREG),
        .FWD_EN (FWD_EN)
    ) u_sb (
        .clk       (CLK),
        .rst       (RST),
        .adv       (pr_wen_c[NREG-1:1]),
        .flush     (pr_flush_c[NREG-1:1]),
        .id_entry  (id_entry),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .hit_c     (hit_c)
    );

    assign dwait_c     = mem_req & ~dhit;
    assign raw_stall_c = id_valid & hit_c;

    // DWAIT behaves as the state it was entered from once dhit arrives
    always_comb begin
        eff_state = state;
        if (state == DWAIT) begin
            eff_state = ret_drain ? DRAIN : RUN;
        end
    end

    assign halt_go_c = (eff_state == RUN) & id_halt & id_valid &
                       ~raw_stall_c & ~redirect & ~dwait_c;

    // Per-cycle pipeline control, highest-priority condition first
    always_comb begin
        pc_wen_c   = 1'b0;
        pr_wen_c   = '0;
        pr_flush_c = '0;
        case (eff_state)
            RUN: begin
                if (dwait_c) begin
                    pc_wen_c = 1'b0;
                end else if (redirect) begin
                    pc_wen_c   = 1'b1;
                    pr_wen_c   = '1;
                    pr_flush_c = BR_MASK;
                end else if (raw_stall_c) begin
                    pr_wen_c      = '1;
                    pr_wen_c[0]   = 1'b0;
                    pr_flush_c[1] = 1'b1;
                end else if (!ihit) begin
                    pr_wen_c      = '1;
                    pr_flush_c[0] = 1'b1;
                end else begin
                    pc_wen_c = 1'b1;
                    pr_wen_c = '1;
                end
            end
            DRAIN: begin
                if (!dwait_c) begin
                    pr_wen_c      = '1;
                    pr_flush_c[0] = 1'b1;
                end
            end
            default: begin
                pc_wen_c = 1'b0;
            end
        endcase
    end

    assign pc_wen   = pc_wen_c;
    assign pr_wen   = pr_wen_c;
    assign pr_flush = pr_flush_c;

    // FSM, drain counter, halted flag and saturating stall counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            ret_drain <= 1'b0;
            dcnt      <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (eff_state)
                RUN: begin
                    if (dwait_c) begin
                        state     <= DWAIT;
                        ret_drain <= 1'b0;
                    end else if (halt_go_c) begin
                        state <= DRAIN;
                        dcnt  <= DCNT_W'(NREG - 1);
                    end else begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (dwait_c) begin
                        state     <= DWAIT;
                        ret_drain <= 1'b1;
                    end else if (dcnt <= DCNT_W'(1)) begin
                        state  <= HALTED;
                        dcnt   <= '0;
                        halted <= 1'b1;
                    end else begin
                        state <= DRAIN;
                        dcnt  <= dcnt - DCNT_W'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
            if ((eff_state == RUN) && !pc_wen_c && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding and non-forwarding instances against a pipeline-level model.
module tb_hazard_ctrl;

    logic       clk;
    logic       RST;
    logic       ihit, dhit, mem_req, id_valid;
    logic [4:0] id_rs, id_rt, id_wsel;
    logic       id_use_rs, id_use_rt, id_wen, id_load, id_halt, redirect;

    logic        pc_wen_f, halted_f;
    logic [3:0]  pr_wen_f, pr_flush_f;
    logic [15:0] stall_cnt_f;
    logic        pc_wen_n, halted_n;
    logic [3:0]  pr_wen_n, pr_flush_n;
    logic [3:0]  stall_cnt_n;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.NSTAGES(5), .BR_STAGE(2), .FWD_EN(1'b1), .CNT_W(16)) u_dut_fwd (
        .CLK(clk), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_wen(id_wen), .id_wsel(id_wsel), .id_load(id_load),
        .id_halt(id_halt), .redirect(redirect), .pc_wen(pc_wen_f), .pr_wen(pr_wen_f),
        .pr_flush(pr_flush_f), .halted(halted_f), .stall_cnt(stall_cnt_f)
    );

    hazard_ctrl #(.NSTAGES(5), .BR_STAGE(2), .FWD_EN(1'b0), .CNT_W(4)) u_dut_nf (
        .CLK(clk), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_wen(id_wen), .id_wsel(id_wsel), .id_load(id_load),
        .id_halt(id_halt), .redirect(redirect), .pc_wen(pc_wen_n), .pr_wen(pr_wen_n),
        .pr_flush(pr_flush_n), .halted(halted_n), .stall_cnt(stall_cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: contents of pipe registers 1..3 as instructions, halt carried as a marker
    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] wsel;
        logic       load;
        logic       hlt;
    } ent_t;

    ent_t m_pipe   [2][1:3];
    bit   m_drain  [2];
    bit   m_halted [2];
    int   m_stall  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        for (int k = 1; k <= 3; k++) m_pipe[i][k] = '0;
        m_drain[i]  = 1'b0;
        m_halted[i] = 1'b0;
        m_stall[i]  = 0;
    endtask

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; id_valid = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wen = 1'b0; id_wsel = 5'd0; id_load = 1'b0; id_halt = 1'b0; redirect = 1'b0;
    endtask

    // One clock: compare both instances at the falling edge, advance the model, return after rise
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit         dw, raw, go, fin, epc;
            logic [3:0] ew, ef;
            ent_t       id_e;
            int         cmax;
            string      nm;
            nm   = (i == 0) ? "fwd" : "nofwd";
            cmax = (i == 0) ? 65535 : 15;
            if (RST) model_reset(i);
            dw  = mem_req && !dhit;
            raw = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                ent_t e;
                bit   reads;
                e = m_pipe[i][k];
                reads = (id_use_rs && id_rs == e.wsel) || (id_use_rt && id_rt == e.wsel);
                if (id_valid && e.valid && e.wen && e.wsel != 5'd0 && reads) begin
                    if (i == 0 ? (k == 1 && e.load) : (k <= 2)) raw = 1'b1;
                end
            end
            if (m_halted[i])      begin epc = 0; ew = 4'b0000; ef = 4'b0000; end
            else if (dw)          begin epc = 0; ew = 4'b0000; ef = 4'b0000; end
            else if (m_drain[i])  begin epc = 0; ew = 4'b1111; ef = 4'b0001; end
            else if (redirect)    begin epc = 1; ew = 4'b1111; ef = 4'b0011; end
            else if (raw)         begin epc = 0; ew = 4'b1110; ef = 4'b0010; end
            else if (!ihit)       begin epc = 0; ew = 4'b1111; ef = 4'b0001; end
            else                  begin epc = 1; ew = 4'b1111; ef = 4'b0000; end
            check({nm, ".pc_wen"},   32'(i == 0 ? pc_wen_f   : pc_wen_n),   32'(epc));
            check({nm, ".pr_wen"},   32'(i == 0 ? pr_wen_f   : pr_wen_n),   32'(ew));
            check({nm, ".pr_flush"}, 32'(i == 0 ? pr_flush_f : pr_flush_n), 32'(ef));
            check({nm, ".halted"},   32'(i == 0 ? halted_f   : halted_n),   32'(m_halted[i]));
            check({nm, ".stall_cnt"}, (i == 0) ? 32'(stall_cnt_f) : 32'(stall_cnt_n),
                  32'(m_stall[i]));
            if (!RST && !m_halted[i]) begin
                go  = !m_drain[i] && !dw && !redirect && !raw && id_halt && id_valid;
                fin = m_drain[i] && !dw && m_pipe[i][3].hlt;
                if (!m_drain[i] && !epc && m_stall[i] < cmax) m_stall[i]++;
                id_e = '{valid: id_valid, wen: id_wen, wsel: id_wsel, load: id_load, hlt: go};
                for (int k = 3; k >= 1; k--) begin
                    if (ef[k])      m_pipe[i][k] = '0;
                    else if (ew[k]) m_pipe[i][k] = (k == 1) ? id_e : m_pipe[i][k-1];
                end
                if (go) m_drain[i] = 1'b1;
                if (fin) begin
                    m_drain[i]  = 1'b0;
                    m_halted[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    task automatic issue(input logic [4:0] wsel, input logic load, input logic [4:0] rs,
                         input logic use_rs);
        idle();
        id_valid = 1'b1; id_wen = 1'b1; id_wsel = wsel; id_load = load;
        id_rs = rs; id_use_rs = use_rs;
    endtask

    int hold;

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // Reset values
        do_reset();
        check("reset halted", 32'(halted_f), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt_f), 32'd0);
        check("reset stall_cnt nofwd", 32'(stall_cnt_n), 32'd0);

        // Load-use: lw $2 then add reading $2
        issue(5'd2, 1'b1, 5'd0, 1'b0); cycle();
        issue(5'd4, 1'b0, 5'd2, 1'b1); #1;
        check("loaduse pc_wen", 32'(pc_wen_f), 32'd0);
        check("loaduse pr_flush", 32'(pr_flush_f), 32'b0010);
        cycle(); #1;
        check("loaduse clean pc_wen", 32'(pc_wen_f), 32'd1);
        check("loaduse clean pr_flush", 32'(pr_flush_f), 32'd0);
        cycle();

        // No forwarding: add $3 then a reader of $3
        do_reset();
        issue(5'd3, 1'b0, 5'd0, 1'b0); cycle();
        issue(5'd6, 1'b0, 5'd3, 1'b1);
        repeat (3) cycle();
        idle(); #1;
        check("nofwd stall_cnt", 32'(stall_cnt_n), 32'd2);
        check("fwd alu no stall_cnt", 32'(stall_cnt_f), 32'd0);

        // Writer of $0 never hazards
        issue(5'd0, 1'b1, 5'd0, 1'b0); cycle();
        issue(5'd7, 1'b0, 5'd0, 1'b1); #1;
        check("r0 fwd pc_wen", 32'(pc_wen_f), 32'd1);
        check("r0 nofwd pc_wen", 32'(pc_wen_n), 32'd1);
        cycle();

        // Data memory wait for 3 cycles, then resume without flush
        idle(); mem_req = 1'b1; dhit = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("dwait pr_wen", 32'(pr_wen_f), 32'd0);
            check("dwait pc_wen", 32'(pc_wen_f), 32'd0);
            cycle();
        end
        dhit = 1'b1; #1;
        check("dwait resume pr_wen", 32'(pr_wen_f), 32'hf);
        check("dwait resume pr_flush", 32'(pr_flush_f), 32'd0);
        cycle();

        // Redirect coinciding with a load-use stall
        issue(5'd2, 1'b1, 5'd0, 1'b0); cycle();
        issue(5'd5, 1'b0, 5'd2, 1'b1); redirect = 1'b1; #1;
        check("redir pc_wen", 32'(pc_wen_f), 32'd1);
        check("redir pr_flush", 32'(pr_flush_f), 32'b0011);
        cycle();

        // HALT drains and reports halted NREG cycles later
        do_reset();
        idle(); id_valid = 1'b1; id_halt = 1'b1; cycle();
        idle(); cycle(); cycle();
        check("halt early", 32'(halted_f), 32'd0);
        cycle();
        check("halt fwd", 32'(halted_f), 32'd1);
        check("halt nofwd", 32'(halted_n), 32'd1);
        cycle(); cycle();

        // Reset in the middle of a drain
        do_reset();
        idle(); id_valid = 1'b1; id_halt = 1'b1; cycle();
        idle(); cycle();
        RST = 1'b1; #1;
        check("rst drain halted", 32'(halted_f), 32'd0);
        check("rst drain pc_wen", 32'(pc_wen_f), 32'd1);
        cycle();
        RST = 1'b0; #1;
        check("after rst pc_wen", 32'(pc_wen_f), 32'd1);
        check("after rst stall_cnt", 32'(stall_cnt_f), 32'd0);
        cycle();

        // Randomized traffic with frequent hazards, waits, redirects and halts
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            id_valid  = ($urandom_range(0, 9) < 8);
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            id_wen    = 1'($urandom_range(0, 1));
            id_wsel   = 5'($urandom_range(0, 3));
            id_load   = 1'($urandom_range(0, 1));
            id_halt   = ($urandom_range(0, 39) == 0);
            redirect  = ($urandom_range(0, 9) == 0);
            ihit      = ($urandom_range(0, 9) != 0);
            mem_req   = ($urandom_range(0, 3) == 0);
            dhit      = ($urandom_range(0, 2) != 0);
            RST       = ($urandom_range(0, 299) == 0) || (hold > 4);
            cycle();
            hold = (m_halted[0] || m_halted[1]) ? hold + 1 : 0;
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
